// File: rtl/logic_unit_pipe_if.sv
// Handshake and result bundle for logic_unit_pipe.
// The parity signal exists only when LOGIC_UNIT_PARITY_EN is defined.
interface logic_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ones;
    logic [CNT_W-1:0] op_count;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity;
`endif

    modport master (
`ifdef LOGIC_UNIT_PARITY_EN
        input  parity,
`endif
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ones, op_count
    );

    modport slave (
`ifdef LOGIC_UNIT_PARITY_EN
        output parity,
`endif
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, ones, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit (AND/OR/XOR/NOR).
// Stage 1 captures operands; stage 2 evaluates and registers result/flags.
// Optional feature macro: LOGIC_UNIT_PARITY_EN adds a registered parity output.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    logic_unit_if.slave   bus
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ones_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity_q;
`endif

    logic             out_adv;
    logic             s1_adv;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] res_d;

    // Pipeline advance controls; in_ready never looks at in_valid.
    always_comb begin
        out_adv  = !out_valid_q | bus.out_ready;
        s1_adv   = s1_valid & out_adv;
        in_ready = !s1_valid | out_adv;
        accept   = bus.in_valid & in_ready;
    end

    // Full 2-bit op decode on the stage-1 registers.
    always_comb begin
        res_d = '0;
        case (s1_op)
            2'b00:   res_d = s1_a & s1_b;
            2'b01:   res_d = s1_a | s1_b;
            2'b10:   res_d = s1_a ^ s1_b;
            default: res_d = ~(s1_a | s1_b);
        endcase
    end

    // Stage 1: capture operands on accept, empty when the beat moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 2'b00;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_op    <= bus.op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register; data and flags hold unless a new beat loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else if (out_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                ones_q   <= &res_d;
`ifdef LOGIC_UNIT_PARITY_EN
                parity_q <= ^res_d;
`endif
            end
        end
    end

    // Saturating count of delivered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.op_count  = cnt_q;
`ifdef LOGIC_UNIT_PARITY_EN
    assign bus.parity    = parity_q;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a 32-bit/16-bit-counter instance for
// the main function and a 1-bit/2-bit-counter instance for flag and
// saturation corners.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();
    logic_unit_if #(.WIDTH(1),  .CNT_W(2))  bus2 ();

    logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic_unit_pipe #(.WIDTH(1),  .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic        exp2_q[$];
    longint      pop_cyc[$];
    longint      cyc = 0;
    int          delivered = 0;
    int          delivered2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            exp_q.delete();
            delivered = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e);
                check("zero", 32'(bus.zero), 32'(e == 32'd0));
                check("ones", 32'(bus.ones), 32'(&e));
`ifdef LOGIC_UNIT_PARITY_EN
                check("parity", 32'(bus.parity), 32'(^e));
`endif
                check("op_count_live", 32'(bus.op_count), 32'(delivered));
                delivered++;
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Monitor for the 1-bit instance (counter saturates at 3).
    always @(negedge clk) begin
        logic e;
        if (!rst_n) begin
            exp2_q.delete();
            delivered2 = 0;
        end else if (bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_out2", 32'(bus2.out_valid), 32'd0);
            end else begin
                e = exp2_q.pop_front();
                check("result2", 32'(bus2.result), 32'(e));
                check("zero2", 32'(bus2.zero), 32'(!e));
                check("ones2", 32'(bus2.ones), 32'(e));
                check("op_count2_live", 32'(bus2.op_count), (delivered2 > 3) ? 32'd3 : 32'(delivered2));
                delivered2++;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
        bit acc = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic send2(input logic [1:0] op, input logic a, input logic b, input logic e);
        bit acc = 0;
        bus2.in_valid = 1'b1;
        bus2.op = op;
        bus2.a = a;
        bus2.b = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (bus2.in_ready) begin
                acc = 1;
                exp2_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send2_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || exp2_q.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_pending2", 32'(exp2_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.op = 2'b00;  bus.a = '0;  bus.b = '0;  bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.op = 2'b00; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_ones", 32'(bus.ones), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef LOGIC_UNIT_PARITY_EN
        check("rst_parity", 32'(bus.parity), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single OR
        send(2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        drain();
        check("t1_op_count", 32'(bus.op_count), 32'd1);

        // 2: all four ops back-to-back, results on consecutive cycles
        n0 = pop_cyc.size();
        send(2'b00, 32'hFFFF_0000, 32'h00FF_00FF, 32'h00FF_0000);
        send(2'b01, 32'hFFFF_0000, 32'h00FF_00FF, 32'hFFFF_00FF);
        send(2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 32'hFF00_00FF);
        send(2'b11, 32'hFFFF_0000, 32'h00FF_00FF, 32'h0000_FF00);
        drain();
        if (pop_cyc.size() >= n0 + 4)
            check("t2_consecutive", 32'(pop_cyc[n0+3] - pop_cyc[n0]), 32'd3);
        else
            check("t2_pop_count", 32'(pop_cyc.size() - n0), 32'd4);

        // 3: flag corners
        send(2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
        send(2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        drain();

        // 4: backpressure with five beats
        bus.out_ready = 1'b0;
        fork
            begin
                send(2'b00, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_000F);
                send(2'b01, 32'hA000_0000, 32'h0000_000A, 32'hA000_000A);
                send(2'b10, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
                send(2'b11, 32'hFFFF_0000, 32'h0000_FFF0, 32'h0000_000F);
                send(2'b00, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_a", bus.result, 32'h0000_000F);
                repeat (3) @(negedge clk);
                check("bp_hold_b", bus.result, 32'h0000_000F);
                check("bp_count_hold", 32'(bus.op_count), 32'd7);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("t4_op_count", 32'(bus.op_count), 32'd12);

        // 5: reset with both stages full, then a single clean beat
        bus.out_ready = 1'b0;
        send(2'b01, 32'h1111_0000, 32'h0000_2222, 32'h1111_2222);
        send(2'b00, 32'hFFFF_FFFF, 32'h7777_7777, 32'h7777_7777);
        #2;
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_op_count", 32'(bus.op_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2'b10, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_FF00);
        drain();
        check("t5_op_count", 32'(bus.op_count), 32'd1);

        // 6: WIDTH=1 flags and CNT_W=2 saturation
        send2(2'b00, 1'b1, 1'b1, 1'b1);
        send2(2'b01, 1'b0, 1'b0, 1'b0);
        send2(2'b10, 1'b1, 1'b0, 1'b1);
        send2(2'b11, 1'b0, 1'b0, 1'b1);
        send2(2'b11, 1'b1, 1'b0, 1'b0);
        drain();
        check("t6_sat", 32'(bus2.op_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
